// File: rtl/fd20_to_fb16.sv
// Sequential 5-digit packed-BCD to 16-bit binary converter (reverse double-dabble).
// One right shift plus per-digit -3 correction per tact, 16 tacts per conversion.
module fd20_to_fb16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] FDI,
  input  logic        st,
  output logic [15:0] FBO,
  output logic [4:0]  cb_tact,
  output logic        EN_conv,
  output logic        ok_conv,
  output logic        err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q;
  logic [19:0] b_q;
  logic [15:0] r_q;

  logic [19:0] b_shift;
  logic [15:0] r_shift;
  logic [19:0] b_next;
  logic        digit_bad;
  logic        last_tact;

  always_comb begin
    b_shift = {1'b0, b_q[19:1]};
    r_shift = {b_q[0], r_q[15:1]};
    b_next  = b_shift;
    // Digits are corrected independently; a digit >= 8 after the shift held a 1 shifted in
    // from the digit above, worth 5 here instead of 8.
    for (int i = 0; i < 5; i++) begin
      if (b_shift[4*i +: 4] >= 4'd8) begin
        b_next[4*i +: 4] = b_shift[4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (FDI[4*i +: 4] > 4'd9) begin
        digit_bad = 1'b1;
      end
    end
  end

  assign last_tact = (cb_tact == 5'd15);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      b_q     <= '0;
      r_q     <= '0;
      FBO     <= '0;
      cb_tact <= '0;
      EN_conv <= 1'b0;
      ok_conv <= 1'b0;
      err     <= 1'b0;
    end else begin
      ok_conv <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (st) begin
            if (digit_bad) begin
              FBO     <= 16'hFFFF;
              err     <= 1'b1;
              ok_conv <= 1'b1;
            end else begin
              b_q     <= FDI;
              r_q     <= '0;
              cb_tact <= '0;
              EN_conv <= 1'b1;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          b_q <= b_next;
          r_q <= r_shift;
          if (last_tact) begin
            // Anything left in B after 16 shifts means the value exceeds 16 bits.
            if (b_next != 20'd0) begin
              FBO <= 16'hFFFF;
              err <= 1'b1;
            end else begin
              FBO <= r_shift;
              err <= 1'b0;
            end
            ok_conv <= 1'b1;
            EN_conv <= 1'b0;
            cb_tact <= '0;
            state_q <= StIdle;
          end else begin
            cb_tact <= cb_tact + 5'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fd20_to_fb16.sv
// Self-checking bench for fd20_to_fb16: directed cases plus a random sweep against a
// decimal-arithmetic reference model.
module tb_fd20_to_fb16;

  logic        clk;
  logic        rst_n;
  logic [19:0] FDI;
  logic        st;
  logic [15:0] FBO;
  logic [4:0]  cb_tact;
  logic        EN_conv;
  logic        ok_conv;
  logic        err;

  int checks;
  int failures;

  fd20_to_fb16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .FDI     (FDI),
    .st      (st),
    .FBO     (FBO),
    .cb_tact (cb_tact),
    .EN_conv (EN_conv),
    .ok_conv (ok_conv),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: decimal value from the digits, then range/validity rules.
  function automatic void ref_model(input logic [19:0] v, output logic [15:0] f,
                                    output logic e, output bit bad);
    int val;
    logic [19:0] tmp;
    tmp = v;
    val = 0;
    bad = 0;
    for (int i = 4; i >= 0; i--) begin
      if (tmp[4*i +: 4] > 4'd9) bad = 1;
      val = val * 10 + int'(tmp[4*i +: 4]);
    end
    if (bad || val > 65535) begin
      f = 16'hFFFF;
      e = 1'b1;
    end else begin
      f = val[15:0];
      e = 1'b0;
    end
  endfunction

  function automatic logic [19:0] to_bcd(input int val);
    logic [19:0] r;
    int x;
    x = val;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Called at a negedge. Starts a conversion with a 1-cycle st pulse, follows every cycle
  // until ok_conv, and checks EN/cb_tact progression, latency and result. When disturb_at
  // is non-negative, st is re-pulsed and FDI changed at that tact.
  task automatic do_conv(input logic [19:0] v, input string tag, input int disturb_at);
    logic [15:0] ef;
    logic        ee;
    bit          bad;
    int          n;
    ref_model(v, ef, ee, bad);
    FDI = v;
    st  = 1'b1;
    @(negedge clk);
    st = 1'b0;
    n = 0;
    while (ok_conv !== 1'b1 && n < 20) begin
      chk({tag, "_en"}, 32'(EN_conv), 32'd1);
      chk({tag, "_tact"}, 32'(cb_tact), 32'(n));
      if (n == disturb_at) begin
        st  = 1'b1;
        FDI = 20'h99999;
      end else if (n == disturb_at + 1) begin
        st = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), bad ? 32'd0 : 32'd16);
    chk({tag, "_ok"}, 32'(ok_conv), 32'd1);
    chk({tag, "_fbo"}, 32'(FBO), 32'(ef));
    chk({tag, "_err"}, 32'(err), 32'(ee));
    chk({tag, "_en_off"}, 32'(EN_conv), 32'd0);
    chk({tag, "_tact_off"}, 32'(cb_tact), 32'd0);
  endtask

  initial begin
    bit seen;
    checks   = 0;
    failures = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    st    = 1'b0;
    FDI   = '0;
    repeat (2) @(negedge clk);
    chk("rst_fbo", 32'(FBO), 32'd0);
    chk("rst_tact", 32'(cb_tact), 32'd0);
    chk("rst_en", 32'(EN_conv), 32'd0);
    chk("rst_ok", 32'(ok_conv), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_conv(20'h19770, "c19770", -1);
    chk("c19770_abs", 32'(FBO), 32'h4D3A);
    @(negedge clk);
    chk("ok_one_cycle", 32'(ok_conv), 32'd0);

    do_conv(20'h00000, "c00000", -1);
    do_conv(20'h65535, "c65535", -1);
    chk("c65535_abs", {15'd0, err, FBO}, {15'd0, 1'b0, 16'hFFFF});
    do_conv(20'h65536, "c65536", -1);
    do_conv(20'h99999, "c99999", -1);
    chk("c99999_abs", {15'd0, err, FBO}, {15'd0, 1'b1, 16'hFFFF});
    @(negedge clk);

    do_conv(20'h1A234, "bad_digit", -1);
    do_conv(20'h00042, "c00042", -1);
    chk("c00042_abs", 32'(FBO), 32'h002A);
    @(negedge clk);

    // st re-pulse mid-run ignored, then back-to-back start in the ok_conv cycle.
    do_conv(20'h12345, "c12345", 5);
    chk("c12345_abs", 32'(FBO), 32'h3039);
    do_conv(20'h00100, "b2b", -1);
    chk("b2b_abs", 32'(FBO), 32'h0064);
    @(negedge clk);

    // Abort by reset at tact 8.
    FDI = 20'h54321;
    st  = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_tact", 32'(cb_tact), 32'd8);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_fbo", 32'(FBO), 32'd0);
    chk("abort_tact0", 32'(cb_tact), 32'd0);
    chk("abort_en", 32'(EN_conv), 32'd0);
    chk("abort_ok", 32'(ok_conv), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ok_conv === 1'b1) seen = 1;
    end
    chk("abort_no_ok", 32'(seen), 32'd0);
    do_conv(20'h00007, "c00007", -1);
    chk("c00007_abs", 32'(FBO), 32'h0007);
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      do_conv(to_bcd(int'($urandom_range(0, 99999))), "rand", -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
